// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Increment that sticks at the given limit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic [CNT_W-1:0] limit);
        if (value >= limit) begin
            return limit;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision: data requests win unless the fetch side has waited
// through STARVE_LIMIT consecutive data grants.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_valid,
    output logic             grant_owner
);

    // Pick an owner whenever anyone is asking; fetch only wins when data is absent or the starvation bound is hit.
    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
        if (d_req && (!i_req || (starve_cnt < CNT_W'(STARVE_LIMIT)))) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller port between instruction fetch and data
// requesters with a request/ready handshake and a fixed access latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    arb_state_t       state;
    arb_state_t       next_state;
    owner_t           owner;
    logic [31:0]      cmd_address;
    logic [31:0]      cmd_wdata;
    logic             cmd_write;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      i_rdata_q;
    logic [31:0]      d_rdata_q;
    logic             grant_valid;
    logic             grant_owner;
    logic             lat_done;

    mem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    assign lat_done = (lat_cnt == CNT_W'(MEM_LATENCY - 1));

    // State register; reset abandons any access in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: grant from IDLE, count out the latency, then one response cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = ACCESS;
            ACCESS:  if (lat_done)    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Command capture at grant, latency and starvation counting, read data retention.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner       <= OWN_I;
            cmd_address <= '0;
            cmd_wdata   <= '0;
            cmd_write   <= 1'b0;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner   <= owner_t'(grant_owner);
                        lat_cnt <= '0;
                        if (grant_owner == OWN_D) begin
                            cmd_address <= d_address;
                            cmd_wdata   <= d_wdata;
                            cmd_write   <= d_write;
                            starve_cnt  <= i_req ? sat_inc(starve_cnt, CNT_W'(STARVE_LIMIT)) : '0;
                        end else begin
                            cmd_address <= i_address;
                            cmd_wdata   <= '0;
                            cmd_write   <= 1'b0;
                            starve_cnt  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
                RESP: begin
                    if (owner == OWN_I) begin
                        i_rdata_q <= mem_rdata;
                    end else if (!cmd_write) begin
                        d_rdata_q <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: strobes only during ACCESS, ready and live read data only during RESP.
    always_comb begin
        busy        = (state != IDLE);
        mem_address = '0;
        mem_wdata   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        i_rdata     = i_rdata_q;
        d_rdata     = d_rdata_q;
        case (state)
            ACCESS: begin
                mem_address = cmd_address;
                mem_read    = !cmd_write;
                mem_write   = cmd_write && (lat_cnt == '0);
                mem_wdata   = cmd_write ? cmd_wdata : '0;
            end
            RESP: begin
                if (owner == OWN_I) begin
                    i_ready = 1'b1;
                    i_rdata = mem_rdata;
                end else begin
                    d_ready = 1'b1;
                    if (!cmd_write) begin
                        d_rdata = mem_rdata;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter checked against a transaction-level
// model that schedules each access by cycle offsets from its grant.
module tb_mem_port_arbiter;

    localparam int ML = 3;
    localparam int SL = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_address = '0;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_address = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    mem_port_arbiter #(
        .MEM_LATENCY (ML),
        .STARVE_LIMIT(SL)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_req      (i_req),
        .i_address  (i_address),
        .i_ready    (i_ready),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Cycle number, stable when sampled on the falling edge.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    bit          m_active = 0;
    bit          m_owner_d = 0;
    bit          m_write = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_i_hold = '0;
    logic [31:0] m_d_hold = '0;
    int          m_start = 0;
    int          m_starve = 0;

    bit was_idle = 1;
    bit cur_dload_access = 0;
    bit resp_i = 0;
    bit resp_d = 0;

    bit i_pend = 0;
    bit i_granted = 0;
    bit d_pend = 0;
    bit d_granted = 0;
    int p_req = 0;
    int p_drop = 0;
    bit wiggle = 0;
    bit collect = 0;
    int order[$];

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Compare every output against where the current transaction should be.
    task automatic check_cycle();
        int          off = cyc - m_start;
        bit          in_tx = m_active && (off >= 0) && (off <= ML);
        bit          acc = in_tx && (off < ML);
        bit          resp = in_tx && (off == ML);
        logic [31:0] e_i_rdata;
        logic [31:0] e_d_rdata;
        was_idle         = !in_tx;
        cur_dload_access = acc && m_owner_d && !m_write;
        resp_i           = resp && !m_owner_d;
        resp_d           = resp && m_owner_d;
        e_i_rdata        = resp_i ? mem_rdata : m_i_hold;
        e_d_rdata        = (resp_d && !m_write) ? mem_rdata : m_d_hold;
        check_output("busy", busy, in_tx);
        check_output("mem_read", mem_read, acc && !m_write);
        check_output("mem_write", mem_write, acc && m_write && (off == 0));
        check_output("mem_address", mem_address, acc ? m_addr : 32'h0);
        if (acc && m_write && (off == 0)) begin
            check_output("mem_wdata", mem_wdata, m_wdata);
        end
        check_output("i_ready", i_ready, resp_i);
        check_output("d_ready", d_ready, resp_d);
        check_output("i_rdata", i_rdata, e_i_rdata);
        check_output("d_rdata", d_rdata, e_d_rdata);
        if (resp) begin
            m_i_hold = e_i_rdata;
            m_d_hold = e_d_rdata;
            m_active = 0;
        end
        if (collect) begin
            if (i_ready) order.push_back(0);
            if (d_ready) order.push_back(1);
        end
    endtask

    // Requesters: raise, hold, occasionally withdraw before grant, and disturb inputs while in flight.
    task automatic apply_stimulus();
        if (resp_i) begin
            i_pend = 0; i_granted = 0; i_req = 1'b0;
        end
        if (resp_d) begin
            d_pend = 0; d_granted = 0; d_req = 1'b0;
        end
        if (!i_pend) begin
            if ($urandom_range(99) < p_req) begin
                i_pend = 1; i_req = 1'b1;
                i_address = $urandom & 32'hFFFF_FFFC;
            end
        end else if (!i_granted) begin
            if ($urandom_range(99) < p_drop) begin
                i_pend = 0; i_req = 1'b0;
            end
        end else if (wiggle) begin
            if ($urandom_range(99) < 30) i_address = $urandom;
            if ($urandom_range(99) < 20) i_req = ~i_req;
        end
        if (!d_pend) begin
            if ($urandom_range(99) < p_req) begin
                d_pend = 1; d_req = 1'b1;
                d_write = 1'($urandom_range(1));
                d_address = $urandom & 32'hFFFF_FFFC;
                d_wdata = $urandom;
            end
        end else if (!d_granted) begin
            if ($urandom_range(99) < p_drop) begin
                d_pend = 0; d_req = 1'b0;
            end
        end else if (wiggle) begin
            if ($urandom_range(99) < 30) d_address = $urandom;
            if ($urandom_range(99) < 30) d_wdata = $urandom;
            if ($urandom_range(99) < 30) d_write = ~d_write;
            if ($urandom_range(99) < 20) d_req = ~d_req;
        end
    endtask

    // Arbitration rule applied to the inputs the next rising edge will see.
    task automatic model_grant();
        if (reset_n && was_idle && (i_req || d_req)) begin
            bit take_d = d_req && (!i_req || (m_starve < SL));
            if (take_d) begin
                m_starve  = i_req ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
                m_owner_d = 1;
                m_write   = d_write;
                m_addr    = d_address;
                m_wdata   = d_wdata;
                d_granted = 1;
            end else begin
                m_starve  = 0;
                m_owner_d = 0;
                m_write   = 0;
                m_addr    = i_address;
                m_wdata   = '0;
                i_granted = 1;
            end
            m_active  = 1;
            m_start   = cyc + 1;
            mem_rdata = $urandom;
        end
    endtask

    task automatic step();
        check_cycle();
        apply_stimulus();
        model_grant();
    endtask

    // Reset wipes the model; granted requesters present their request again.
    task automatic model_reset();
        m_active = 0;
        m_starve = 0;
        m_i_hold = '0;
        m_d_hold = '0;
        resp_i   = 0;
        resp_d   = 0;
        if (i_granted) begin i_granted = 0; i_req = 1'b1; end
        if (d_granted) begin d_granted = 0; d_req = 1'b1; end
    endtask

    initial begin
        int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        bit hit = 0;
        int rel = 0;
        int lat = -1;

        repeat (3) begin
            @(negedge clock);
            step();
        end

        @(negedge clock);
        reset_n = 1'b1;
        p_req = 100; p_drop = 0; wiggle = 0; collect = 1;
        step();
        for (int n = 0; n < 300 && order.size() < 10; n++) begin
            @(negedge clock);
            step();
        end
        collect = 0;
        check_output("contention_len", order.size(), 10);
        for (int i = 0; i < 10 && i < order.size(); i++) begin
            check_output($sformatf("contention_grant%0d", i), order[i], exp_order[i]);
        end

        p_req = 40; p_drop = 15; wiggle = 1;
        repeat (3000) begin
            @(negedge clock);
            step();
        end

        for (int n = 0; n < 3000 && !hit; n++) begin
            @(negedge clock);
            step();
            if (cur_dload_access) hit = 1;
        end
        check_output("reset_hit", hit, 1);
        if (hit) begin
            p_req = 0; p_drop = 0;
            reset_n = 1'b0;
            #1;
            check_output("rst_busy", busy, 0);
            check_output("rst_mem_read", mem_read, 0);
            check_output("rst_mem_write", mem_write, 0);
            check_output("rst_mem_address", mem_address, 0);
            check_output("rst_mem_wdata", mem_wdata, 0);
            check_output("rst_d_ready", d_ready, 0);
            check_output("rst_i_ready", i_ready, 0);
            check_output("rst_d_rdata", d_rdata, 0);
            check_output("rst_i_rdata", i_rdata, 0);
            model_reset();
            @(negedge clock);
            step();
            @(negedge clock);
            reset_n = 1'b1;
            rel = cyc;
            step();
            for (int n = 0; n < 20; n++) begin
                @(negedge clock);
                step();
                if (d_ready) begin
                    lat = cyc - rel;
                    break;
                end
            end
            check_output("reset_regrant_latency", lat, ML + 1);
        end

        p_req = 40; p_drop = 15; wiggle = 1;
        repeat (500) begin
            @(negedge clock);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single shared memory port (ROM/RAM/peripheral space) between the instruction-fetch requester (L1I) and the data requester (L1D).
- Replaces combinational stalling with a request/ready handshake, a fixed-latency access counter and starvation-bounded data priority.
- Sits between the L1 caches and the memory controller's address/data/strobe inputs.

Parameters:
- MEM_LATENCY, 1, cycles from command issue to valid mem_rdata / write completion (1..15).
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits (1..15).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction fetch request; held until i_ready
- i_address  in  32  fetch byte address
- i_ready  out  1  one-cycle pulse: i_rdata valid, request retired
- i_rdata  out  32  fetched word
- d_req  in  1  data request; held until d_ready
- d_write  in  1  1 = store, 0 = load; sampled at grant
- d_address  in  32  data byte address
- d_wdata  in  32  store data
- d_ready  out  1  one-cycle pulse: load data valid or store done
- d_rdata  out  32  load word
- mem_address  out  32  address to memory controller
- mem_wdata  out  32  write data to memory controller
- mem_read  out  1  read strobe, held for whole access
- mem_write  out  1  write strobe, one cycle at issue only
- mem_rdata  in  32  read data from memory controller
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all outputs 0; latency counter, starvation counter and owner register cleared.
  - Reset mid-access abandons the access with no ready pulse.
  - Requesters re-present after reset.
- States:
  - IDLE: choose owner.
    - d_req && (!i_req || starve_cnt < STARVE_LIMIT) -> owner=D.
    - Else if i_req -> owner=I.
    - Else stay.
    - On grant, register address, wdata and write into internal regs -> ACCESS; lat_cnt=0.
  - ACCESS: drive mem_address/mem_read (or mem_write on the first ACCESS cycle only) from the registered command.
    - lat_cnt increments each cycle.
    - When lat_cnt == MEM_LATENCY-1 -> RESP.
  - RESP:
    - Capture mem_rdata into i_rdata or d_rdata for reads; d_rdata is unchanged for stores.
    - Pulse the owner's ready for exactly 1 cycle, then -> IDLE.
- Latency: request seen in IDLE at cycle t -> ready at cycle t+1+MEM_LATENCY.
  - Minimum back-to-back turnaround is MEM_LATENCY+2 cycles per access.
- Starvation counter (4 bits, saturating at STARVE_LIMIT):
  - Increments on each D grant made while i_req=1.
  - Clears on any I grant, and on a D grant made while i_req=0.
- Simultaneous i_req && d_req: D wins unless starve_cnt == STARVE_LIMIT, in which case I wins and the counter clears.
- Request deassertion:
  - A request dropped before grant is ignored.
  - Once granted, the access completes even if the request drops; the ready pulse is still issued.
- Command capture: the registered command is immune to input changes during ACCESS/RESP.
- Strobes: mem_read and mem_write are never both 1; both are 0 in IDLE and RESP.
- Read data: i_rdata/d_rdata hold their last captured value between pulses.
- Address handling: no address translation; the downstream controller decodes ROM/RAM/peripheral space.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - owner encoding OWN_I=1'b0, OWN_D=1'b1.
  - counter width constant CNT_W=4.
- One natural sub-module: mem_arb_select, the combinational grant decision taking i_req, d_req, starve_cnt and STARVE_LIMIT and returning grant_valid and grant_owner. It is tested standalone for priority and starvation.
- The FSM, counters and datapath registers live in the top module.

Test Plan:
- Reset mid-access: d_req load at 0x84, assert reset_n=0 during ACCESS -> all outputs 0 immediately; no d_ready; after release with d_req still high, a fresh access issues and d_ready pulses MEM_LATENCY+1 cycles later.
- Single fetch, MEM_LATENCY=1: i_req, i_address=0x10, mem_rdata=0xDEADBEEF -> mem_read=1 for 1 cycle; i_ready=1 at t+2 with i_rdata=0xDEADBEEF; busy high for 2 cycles.
- Store: d_req, d_write=1, d_address=0x80, d_wdata=0x12345678 -> mem_write=1 for exactly one cycle with mem_address=0x80 and mem_wdata=0x12345678; d_ready pulses; d_rdata unchanged.
- Contention, STARVE_LIMIT=4: i_req and d_req held continuously -> grant order D,D,D,D,I,D,D,D,D,I; no two consecutive ready pulses from I while d_req is held.
- MEM_LATENCY=3 with input change: grant load at 0x90, then change d_address to 0xA0 during ACCESS -> mem_address stays 0x90 for 3 cycles; d_ready at t+4.
- Early drop: i_req pulses 1 cycle while D owns the port -> no I grant, i_ready never asserts, starve_cnt returns to 0 on the next D grant with i_req=0.
